// File: rtl/sv39_ptw_lite.sv
// rtl/sv39_ptw_lite.sv - Sv39 page-table walker filling a TLB on miss, one PTE read outstanding.
// Optional walk counter gated by SV39_PTW_LITE_WALK_CNT_EN.
module sv39_ptw_lite #(
    parameter int ASID_WIDTH     = 1,
    parameter int WALK_CNT_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      miss_i,
    input  logic [38:0]               miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0]     miss_asid_i,
    input  logic [43:0]               satp_ppn_i,
    output logic                      busy_o,
    output logic                      mem_req_o,
    output logic [55:0]               mem_addr_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [63:0]               mem_rdata_i,
    output logic                      update_valid_o,
    output logic [26:0]               update_vpn_o,
    output logic [ASID_WIDTH-1:0]     update_asid_o,
    output logic [63:0]               update_content_o,
    output logic                      update_is_2M_o,
    output logic                      update_is_1G_o,
`ifdef SV39_PTW_LITE_WALK_CNT_EN
    output logic [WALK_CNT_WIDTH-1:0] walk_cnt_o,
`endif
    output logic                      fault_o,
    output logic [38:0]               fault_vaddr_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_FLUSHED = 2'd3;

    logic [1:0]            state_q;
    logic [1:0]            level_q;
    logic [38:0]           vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic [43:0]           ppn_q;
    logic [8:0]            vpn_sel;

    logic pte_v, pte_r, pte_w, pte_x, pte_a;
    logic pte_invalid, pte_leaf, pte_misaligned, pte_descend, pte_ok;

    always_comb begin
        vpn_sel = vaddr_q[20:12];
        case (level_q)
            2'd2:    vpn_sel = vaddr_q[38:30];
            2'd1:    vpn_sel = vaddr_q[29:21];
            default: vpn_sel = vaddr_q[20:12];
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign mem_req_o  = (state_q == S_REQ);
    // Carry out of bit 55 is simply dropped.
    assign mem_addr_o = mem_req_o ? ({ppn_q, 12'b0} + {44'b0, vpn_sel, 3'b0}) : 56'b0;

    assign pte_v = mem_rdata_i[0];
    assign pte_r = mem_rdata_i[1];
    assign pte_w = mem_rdata_i[2];
    assign pte_x = mem_rdata_i[3];
    assign pte_a = mem_rdata_i[6];

    assign pte_invalid    = !pte_v || (!pte_r && pte_w);
    assign pte_leaf       = pte_r || pte_x;
    assign pte_misaligned = ((level_q == 2'd2) && (mem_rdata_i[27:10] != 18'b0))
                         || ((level_q == 2'd1) && (mem_rdata_i[18:10] != 9'b0));
    assign pte_descend    = !pte_invalid && !pte_leaf && (level_q != 2'd0);
    assign pte_ok         = !pte_invalid && pte_leaf && pte_a && !pte_misaligned;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            level_q          <= 2'd2;
            vaddr_q          <= '0;
            asid_q           <= '0;
            ppn_q            <= '0;
            update_valid_o   <= 1'b0;
            update_vpn_o     <= '0;
            update_asid_o    <= '0;
            update_content_o <= '0;
            update_is_2M_o   <= 1'b0;
            update_is_1G_o   <= 1'b0;
            fault_o          <= 1'b0;
        end else begin
            update_valid_o   <= 1'b0;
            update_vpn_o     <= '0;
            update_asid_o    <= '0;
            update_content_o <= '0;
            update_is_2M_o   <= 1'b0;
            update_is_1G_o   <= 1'b0;
            fault_o          <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (miss_i && !flush_i) begin
                        vaddr_q <= miss_vaddr_i;
                        asid_q  <= miss_asid_i;
                        ppn_q   <= satp_ppn_i;
                        level_q <= 2'd2;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A grant in the flush cycle still leaves a response to drain.
                    if (flush_i)        state_q <= mem_gnt_i ? S_FLUSHED : S_IDLE;
                    else if (mem_gnt_i) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (flush_i) begin
                            state_q <= S_IDLE;
                        end else if (pte_descend) begin
                            ppn_q   <= mem_rdata_i[53:10];
                            level_q <= level_q - 2'd1;
                            state_q <= S_REQ;
                        end else if (pte_ok) begin
                            update_valid_o   <= 1'b1;
                            update_vpn_o     <= vaddr_q[38:12];
                            update_asid_o    <= asid_q;
                            update_content_o <= mem_rdata_i;
                            update_is_1G_o   <= (level_q == 2'd2);
                            update_is_2M_o   <= (level_q == 2'd1);
                            state_q          <= S_IDLE;
                        end else begin
                            fault_o <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (flush_i) begin
                        state_q <= S_FLUSHED;
                    end
                end
                default: begin
                    if (mem_rvalid_i) state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fault_vaddr_o = fault_o ? vaddr_q : 39'b0;

`ifdef SV39_PTW_LITE_WALK_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)                         walk_cnt_o <= '0;
        else if (update_valid_o || fault_o) walk_cnt_o <= walk_cnt_o + {{(WALK_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
`else
    localparam int unused_walk_cnt_width = WALK_CNT_WIDTH;
`endif

endmodule

// File: tb/tb_sv39_ptw_lite.sv
// tb/tb_sv39_ptw_lite.sv - directed self-checking bench for sv39_ptw_lite.
module tb_sv39_ptw_lite;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        miss_i = 1'b0;
    logic [38:0] miss_vaddr_i = '0;
    logic [0:0]  miss_asid_i = '0;
    logic [43:0] satp_ppn_i = '0;
    logic        busy_o;
    logic        mem_req_o;
    logic [55:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        update_valid_o;
    logic [26:0] update_vpn_o;
    logic [0:0]  update_asid_o;
    logic [63:0] update_content_o;
    logic        update_is_2M_o;
    logic        update_is_1G_o;
    logic        fault_o;
    logic [38:0] fault_vaddr_o;
`ifdef SV39_PTW_LITE_WALK_CNT_EN
    logic [1:0]  walk_cnt_o;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int start;

    always #5 clk_i = ~clk_i;

    sv39_ptw_lite #(
        .ASID_WIDTH    (1),
`ifdef SV39_PTW_LITE_WALK_CNT_EN
        .WALK_CNT_WIDTH(2)
`else
        .WALK_CNT_WIDTH(32)
`endif
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .miss_i          (miss_i),
        .miss_vaddr_i    (miss_vaddr_i),
        .miss_asid_i     (miss_asid_i),
        .satp_ppn_i      (satp_ppn_i),
        .busy_o          (busy_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .update_valid_o  (update_valid_o),
        .update_vpn_o    (update_vpn_o),
        .update_asid_o   (update_asid_o),
        .update_content_o(update_content_o),
        .update_is_2M_o  (update_is_2M_o),
        .update_is_1G_o  (update_is_1G_o),
`ifdef SV39_PTW_LITE_WALK_CNT_EN
        .walk_cnt_o      (walk_cnt_o),
`endif
        .fault_o         (fault_o),
        .fault_vaddr_o   (fault_vaddr_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_miss(input logic [38:0] va, input logic asid);
        miss_vaddr_i = va;
        miss_asid_i  = asid;
        satp_ppn_i   = 44'h80000;
        miss_i       = 1'b1;
        start        = cyc;
        tick();
        miss_i       = 1'b0;
    endtask

    // Zero-wait read: grant in the request cycle, data the next cycle.
    task automatic serve(input string tag, input logic [55:0] exp_addr, input logic [63:0] pte);
        chk({tag, "_req"}, mem_req_o, 1);
        chk({tag, "_addr"}, mem_addr_o, exp_addr);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pte;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_upd", update_valid_o, 0);
        chk("rst_vpn", update_vpn_o, 0);
        chk("rst_content", update_content_o, 0);
        chk("rst_flags", {update_is_1G_o, update_is_2M_o}, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_fvaddr", fault_vaddr_o, 0);
        rst_i = 1'b0;
        tick();

        // Full 3-level 4K walk
        start_miss(39'h0040201000, 1'b1);
        chk("w4k_busy", busy_o, 1);
        serve("w4k_l2", 56'h80000008, 64'h20000401);
        serve("w4k_l1", 56'h80001008, 64'h20000801);
        serve("w4k_l0", 56'h80002008, 64'h200000CF);
        chk("w4k_latency", cyc - start, 7);
        chk("w4k_upd", update_valid_o, 1);
        chk("w4k_vpn", update_vpn_o, 27'h40201);
        chk("w4k_content", update_content_o, 64'h200000CF);
        chk("w4k_asid", update_asid_o, 1);
        chk("w4k_flags", {update_is_1G_o, update_is_2M_o}, 0);
        chk("w4k_fault", fault_o, 0);
        tick();
        chk("w4k_pulse", update_valid_o, 0);
        chk("w4k_idle", busy_o, 0);

        // 1G leaf at level 2; a second miss during the walk is ignored
        start_miss(39'h0040201000, 1'b0);
        miss_i       = 1'b1;
        miss_vaddr_i = 39'h7FFFFFF000;
        serve("w1g_l2", 56'h80000008, 64'h200000CF);
        miss_i = 1'b0;
        chk("w1g_upd", update_valid_o, 1);
        chk("w1g_vpn", update_vpn_o, 27'h40201);
        chk("w1g_1G", update_is_1G_o, 1);
        chk("w1g_2M", update_is_2M_o, 0);
        chk("w1g_fault", fault_o, 0);
        tick();
        chk("w1g_ignored_miss", busy_o, 0);

        // Misaligned 2M leaf
        start_miss(39'h0040201000, 1'b0);
        serve("mis_l2", 56'h80000008, 64'h20000401);
        serve("mis_l1", 56'h80001008, 64'h200004CF);
        chk("mis_fault", fault_o, 1);
        chk("mis_fvaddr", fault_vaddr_o, 39'h0040201000);
        chk("mis_upd", update_valid_o, 0);
        tick();
        chk("mis_pulse", fault_o, 0);
        chk("mis_fvaddr_clr", fault_vaddr_o, 0);

        // Invalid PTEs: V=0, then W without R
        start_miss(39'h0040201000, 1'b0);
        serve("inv0", 56'h80000008, 64'h0);
        chk("inv0_fault", fault_o, 1);
        chk("inv0_upd", update_valid_o, 0);
        tick();
        start_miss(39'h0040201000, 1'b0);
        serve("invw", 56'h80000008, 64'h5);
        chk("invw_fault", fault_o, 1);
        tick();
`ifdef SV39_PTW_LITE_WALK_CNT_EN
        chk("cnt_wrap", walk_cnt_o, 2'd1);
`endif

        // Flush after grant: drain the response, no fill
        start_miss(39'h0040201000, 1'b0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        flush_i   = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_busy1", busy_o, 1);
        tick();
        chk("fl_busy2", busy_o, 1);
        chk("fl_noreq", mem_req_o, 0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h200000CF;
        tick();
        mem_rvalid_i = 1'b0;
        chk("fl_idle", busy_o, 0);
        chk("fl_upd", update_valid_o, 0);
        chk("fl_fault", fault_o, 0);

        // Flush in REQ before grant
        start_miss(39'h0040201000, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flreq_busy", busy_o, 0);
        chk("flreq_req", mem_req_o, 0);

        // Flush and miss together in IDLE
        miss_i  = 1'b1;
        flush_i = 1'b1;
        tick();
        miss_i  = 1'b0;
        flush_i = 1'b0;
        chk("flmiss_busy", busy_o, 0);

        // Flush coincident with rvalid
        start_miss(39'h0040201000, 1'b0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h200000CF;
        flush_i      = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        flush_i      = 1'b0;
        chk("flrv_busy", busy_o, 0);
        chk("flrv_upd", update_valid_o, 0);
        chk("flrv_fault", fault_o, 0);

        // Reset in WAIT, stray rvalid afterwards
        start_miss(39'h0040201000, 1'b1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst_i     = 1'b1;
        tick();
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h200000CF;
        chk("rw_busy", busy_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        chk("rw_busy2", busy_o, 0);
        chk("rw_req", mem_req_o, 0);
        chk("rw_addr", mem_addr_o, 0);
        chk("rw_upd", update_valid_o, 0);
        chk("rw_fault", fault_o, 0);
`ifdef SV39_PTW_LITE_WALK_CNT_EN
        chk("rw_cnt", walk_cnt_o, 2'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
